// File: rtl/lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_arbiter
// Purpose  : Round-robin arbiter sharing the single write port of the LCD
//            bitmap memory updater among NREQ requesters. One write is taken
//            per grant and forwarded as a one-cycle request pulse with
//            registered din/addr. Consecutive pulses are spaced GAP cycles
//            apart so the updater's read-modify-write always completes first.
// Ports    : clk        - system clock, rising edge
//            nrst       - asynchronous active-low reset
//            req        - per-requester write request (level, held until ack)
//            din_flat   - pixel bytes, requester i at [8i+7:8i]
//            addr_flat  - bitmap addresses, requester i at [8i+7:8i]
//            ack        - one-hot, one-cycle "write taken" pulse
//            request    - one-cycle write strobe to the memory updater
//            din/addr   - registered data/address for the memory updater
//            busy       - high while issuing or waiting out the gap
//            grant_id   - index of the last granted requester
// Revision : 1.0 - initial release
// ============================================================================
module lcd_write_arbiter #(
    parameter int NREQ = 4,
    parameter int GAP  = 4,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    din_flat,
    input  logic [8*NREQ-1:0]    addr_flat,
    output logic [NREQ-1:0]      ack,
    output logic                 request,
    output logic [7:0]           din,
    output logic [7:0]           addr,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id
);

    localparam int c_cnt_w = $clog2(GAP + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    // WAIT spans GAP-2 cycles: counter runs GAP-2 down to 1
    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(GAP - 2);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    // last served starts at NREQ-1 so requester 0 wins first after reset
    localparam logic [ID_W-1:0]    c_last_rst  = ID_W'(NREQ - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ID_W-1:0]    r_last;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_idx;
    logic               w_found;
    logic               w_any;
    logic [7:0]         r_din;
    logic [7:0]         r_addr;
    logic [7:0]         w_din_sel;
    logic [7:0]         w_addr_sel;

    // ------------------------------------------------------------------------
    // Round-robin search: scan from last+1 upward (mod NREQ), first hit wins.
    // Only registered state and req feed this; the result is only used to
    // load registers, so req never reaches ack/request combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        w_any    = |req;
        w_found  = 1'b0;
        w_winner = r_last;
        w_idx    = r_last;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = ID_W'((int'(r_last) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_din_sel  = din_flat[7:0];
        w_addr_sel = addr_flat[7:0];
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_din_sel  = din_flat[8*i +: 8];
                w_addr_sel = addr_flat[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic (req is only looked at in IDLE)
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_any) w_state_next = c_st_issue;
            c_st_issue: w_state_next = c_st_wait;
            c_st_wait:  if (r_cnt == c_cnt_one) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Grant bookkeeping, write latch and gap counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last <= c_last_rst;
            r_din  <= 8'h00;
            r_addr <= 8'h00;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_last <= w_winner;
                        r_din  <= w_din_sel;
                        r_addr <= w_addr_sel;
                    end
                end
                c_st_issue: r_cnt <= c_wait_load;
                c_st_wait:  r_cnt <= r_cnt - c_cnt_one;
                default:    r_cnt <= r_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. ISSUE lasts exactly one cycle, which makes request and
    // the ack bit of the latched winner single-cycle pulses.
    // ------------------------------------------------------------------------
    always_comb begin
        request = (r_state == c_st_issue);
        busy    = (r_state == c_st_issue) || (r_state == c_st_wait);
        ack     = '0;
        if (r_state == c_st_issue) begin
            ack[r_last] = 1'b1;
        end
    end

    assign din      = r_din;
    assign addr     = r_addr;
    assign grant_id = r_last;

endmodule
`default_nettype wire

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Round-robin arbiter that shares the single write port of the LCD bitmap updater (`request`/`din`/`addr` of `lcd_driver`) between several independent requesters, such as a text renderer, a graphics engine and the HPS bridge. It accepts one write per grant and forwards it as a one-cycle `request` pulse with registered `din`/`addr`. It then enforces a minimum spacing of `GAP` cycles before the next pulse, so that the read-modify-write in the memory updater always completes before the next write arrives.

## Interface
- `NREQ`, default 4: number of requesters, 1..8.
- `GAP`, default 4: minimum clock cycles between consecutive `request` pulses, ≥3; must cover the memory updater RMW latency.
- `clk`  in  1  50 MHz system clock; all logic on rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester write request, level; held until the matching `ack` bit pulses.
- `din_flat`  in  8*NREQ  pixel byte; requester i occupies bits [8i+7:8i]; stable while `req[i]` is high.
- `addr_flat`  in  8*NREQ  bitmap address; requester i occupies bits [8i+7:8i]; stable while `req[i]` is high.
- `ack`  out  NREQ  one-cycle, one-hot pulse: the request has been taken.
- `request`  out  1  one-cycle write strobe to the memory updater.
- `din`  out  8  registered data to the memory updater.
- `addr`  out  8  registered address to the memory updater; passed through unchanged.
- `busy`  out  1  high in ISSUE and WAIT.
- `grant_id`  out  max(1,$clog2(NREQ))  index of the last granted requester.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:**
  - If any `req` bit is high, select the winner by round-robin search starting at `ptr = (last + 1) mod NREQ`.
  - On the clock edge: latch the winner's `din`/`addr` slices and set `last` to the winner. Assert `ack[winner]` and `request` (both registered). Go to ISSUE.
  - If no `req` bit is high, stay in IDLE.
- **ISSUE** (1 cycle):
  - `request` = 1 and `ack[winner]` = 1 for exactly this cycle.
  - Load the wait counter with GAP-2. Go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - When it reaches 1 on a clock edge, go to IDLE; WAIT lasts GAP-2 cycles in total.
  - `req` is ignored during WAIT.
- **Requester rule:**
  - A requester may drop `req` or present new data from the cycle after its `ack`.
  - A `req` still high in IDLE after an `ack` is treated as a new write.
- **Round-robin:**
  - `last` resets to NREQ-1, so requester 0 has highest priority after reset.
  - A requester that was just served becomes lowest priority.
  - With NREQ=1, requester 0 is always selected.
- `din`/`addr` hold their last latched value between grants; they are only meaningful while `request` = 1.
- **Reset:**
  - `nrst` low immediately forces IDLE and `last` = NREQ-1.
  - All outputs go to 0: `request`, `ack`, `din`, `addr`, `busy`. `grant_id` reads NREQ-1.
  - A grant in flight is aborted and no `ack` is produced.
  - The requester must re-present its write after reset.

## Timing
- **Latency:** `req` sampled high in IDLE at edge T gives `request` = `ack` = 1 during cycle T+1 (ISSUE).
- **Pulse spacing:** consecutive `request` pulses are exactly GAP cycles apart under continuous demand. This is 1 ISSUE cycle, GAP-2 WAIT cycles and 1 IDLE decision cycle.
- **Throughput:** one write per GAP cycles, shared fairly. Under full load, each requester is served once every NREQ*GAP cycles.
- **Simultaneous events:** multiple `req` rising in the same cycle resolve strictly by round-robin order. No combinational path runs from `req` to `ack` or `request`.

## Test plan
- **Single write after reset:** `req` = 0001, `din` = 0xA5, `addr` = 0x12. The cycle after the sampling edge shows `request` = 1, `din` = 0xA5, `addr` = 0x12 and `ack` = 0001, each for exactly 1 cycle. After that, `busy` stays high for GAP-2 cycles.
- **All four requesting continuously** (NREQ=4, GAP=4): grants go 0,1,2,3,0,… with `request` pulses exactly 4 cycles apart. Each `ack` bit pulses once per 16 cycles.
- **Fairness after skip:** `req` = 1010 with `last` = 1. Grant goes to 3, then 1, then 3.
- **Back-to-back from one requester:** requester 2 keeps `req` high and changes `din` after each `ack`. Every `request` carries the new byte; none is duplicated or lost.
- **Reset mid-operation:** assert `nrst` = 0 during ISSUE. `request`, `ack` and `busy` drop to 0 immediately. After release, `req` = 0001 is served again in the first IDLE cycle.
- **GAP=3, NREQ=1 corner:** with `req` held high, `request` pulses every 3 cycles and WAIT lasts exactly 1 cycle.
